ym3438_pg_phase: RTL
====================

# ym3438_pg_phase

Phase generator stage that consumes the LFO-modulated frequency number, `fnum_lfo`, produced by the LFO/PM block. It converts it into a per-slot phase increment using block, detune and multiple. It then accumulates a 20-bit phase for each of the 24 operator slots in a time-multiplexed ring. The top 10 phase bits go downstream to the operator (sine lookup) stage, one slot per slot step.

## Interface
Parameters:
- `SLOTS`, default 24: number of time-multiplexed slots, equal to the ring depth. Must be ≥ 4.
- `PHASE_W`, default 20: accumulator width.

Ports:
- `MCLK` in 1: the single clock. All state updates on the rising edge.
- `IC` in 1: asynchronous, active-low reset. Clears all state while low.
- `slot_en` in 1: slot-step strobe. The pipeline and ring advance only on edges where it is 1.
- `fnum_lfo` in 12: 2×fnum plus signed LFO PM offset, for the slot presented this step.
- `block` in 3: octave.
- `multi` in 4: frequency multiple; 0 means ×½.
- `dt_val` in 6: signed detune offset, two's complement, range −32..+31.
- `pg_reset` in 1: key-on phase reset for this slot.
- `phase_out` out 10: accumulated `phase[19:10]` of the slot retired this step.

## Operation
- Slot order is implicit: one slot is presented per `slot_en` step, cycling through `SLOTS` slots. The block holds no slot counter.
- Stage A (register on step):
  - `freq_a = ({5'b0, fnum_lfo} << block) >> 2`, 17 bits, no loss.
  - `pg_reset` is carried along.
- Stage B:
  - `freq_b = (freq_a + sign_extend(dt_val)) mod 2^17`.
  - Underflow and overflow wrap, with no saturation.
- Stage C (increment):
  - If `multi == 0`, `inc = freq_b >> 1`.
  - Otherwise `inc = (freq_b * multi) mod 2^20`, with bit 20 discarded.
- Accumulator ring:
  - The ring is a `SLOTS`-deep shift register of `PHASE_W`-bit entries.
  - On each step, the tail entry (the same slot's phase from `SLOTS` steps earlier) is popped.
  - The new head is `new = rst_c ? 0 : (tail + inc) mod 2^20`.
  - `new` is pushed at the head, and `phase_out <= new[19:10]`.
- When `pg_reset` is set, the slot's phase becomes exactly 0 on that visit, and `phase_out` for that visit is 0. The increment is not added.
- Only `pg_reset` clears state. No other input clears it.
- `slot_en = 0`: every register, ring entry and `phase_out` holds its value.

## Timing
- Latency: inputs sampled on step edge k produce `phase_out` after step edge k+3 (stages A, B, C→ring/output).
- Throughput: one slot per `slot_en` step. `slot_en` may be held high every MCLK edge.
- Reset: `IC` low asynchronously clears to 0, with no MCLK needed:
  - stage registers;
  - all `SLOTS` ring entries;
  - `phase_out`.
- Release is synchronous with the next MCLK edge. The first step after release uses zeroed pipeline contents, so the first 3 outputs derive from increment 0.
- Reset asserted mid-operation discards all accumulated phase. There is no partial retention.
- `pg_reset` and a non-zero increment on the same visit: reset wins, and the result is 0.
- Wrap-around: the phase wraps modulo 2^20 with no flag.
- Extremes:
  - `block = 7` with `fnum_lfo = 0xFFF` is representable in 17 bits.
  - A 17-bit × 15 product truncates to 20 bits.

## Test plan
- Steady tone:
  - Stimulus, all slots: `fnum_lfo = 0x400`, `block = 4`, `multi = 1`, `dt_val = 0`, `slot_en` = 1 continuously.
  - Required: `inc = 0x1000`, and slot s's n-th output (n ≥ 1 after pipeline fill) equals 4n mod 1024.
  - With `multi = 0`: 2n.
- Wrap and truncation:
  - Stimulus: `fnum_lfo = 0xFFF`, `block = 7`, `dt_val = +5`, `multi = 15`.
  - Required: `freq_b = 0x1FFE5`, `inc = 0xDFE6B`.
  - Check the accumulated phase against a mod-2^20 model across ≥ 3 wraps.
- Detune underflow:
  - Stimulus: `fnum_lfo = 0`, `block = 0`, `dt_val = −1`, `multi = 1`.
  - Required: `inc = 0x1FFFF`. The first visit's `phase_out` is 0x07F, and the second is 0x0FF.
- Key-on reset:
  - Stimulus: run a tone, then assert `pg_reset` for one visit of slot 5 only.
  - Required: that visit outputs 0, and the next visit outputs `inc >> 10`.
  - All other slots are unaffected.
- Stall:
  - Stimulus: drop `slot_en` for 7 MCLK edges mid-stream.
  - Required: `phase_out` is frozen, and the output sequence after resuming is identical to an unstalled run.
- Async reset:
  - Stimulus: assert `IC` between MCLK edges during activity.
  - Required: `phase_out` goes to 0 immediately.
  - After release, all slots restart from phase 0, with the first valid non-zero output at the 4th step.

Source files
------------

// File: rtl/ym3438_pg_phase.sv
// Phase generator: turns the LFO-modulated fnum into a per-slot increment and
// accumulates a 20-bit phase per slot in a time-multiplexed ring.
`timescale 1ns/1ps
module ym3438_pg_phase #(
    parameter int SLOTS   = 24,
    parameter int PHASE_W = 20
) (
    input  logic        MCLK,
    input  logic        IC,
    input  logic        slot_en,
    input  logic [11:0] fnum_lfo,
    input  logic [2:0]  block,
    input  logic [3:0]  multi,
    input  logic [5:0]  dt_val,
    input  logic        pg_reset,
    output logic [9:0]  phase_out
);

    logic [16:0]        r_freq_a;
    logic [5:0]         r_dt_a;
    logic [3:0]         r_multi_a;
    logic               r_rst_a;

    logic [16:0]        r_freq_b;
    logic [3:0]         r_multi_b;
    logic               r_rst_b;

    logic [PHASE_W-1:0] r_inc_c;
    logic               r_rst_c;

    logic [PHASE_W-1:0] r_ring [SLOTS];

    logic [18:0]        w_shift;
    logic [16:0]        w_freq_a;
    logic [16:0]        w_freq_b;
    logic [20:0]        w_prod;
    logic [20:0]        w_inc;
    logic [PHASE_W-1:0] w_new;

    // Block shift widens to 19 bits before dropping two LSBs, so block 7 fits.
    assign w_shift  = {7'b0, fnum_lfo} << block;
    assign w_freq_a = w_shift[18:2];
    assign w_freq_b = r_freq_a + {{11{r_dt_a[5]}}, r_dt_a};
    assign w_prod   = {4'b0, r_freq_b} * {17'b0, r_multi_b};
    assign w_inc    = (r_multi_b == 4'd0) ? {5'b0, r_freq_b[16:1]} : w_prod;
    assign w_new    = r_rst_c ? '0 : r_ring[SLOTS-1] + r_inc_c;

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_freq_a  <= '0;
            r_dt_a    <= '0;
            r_multi_a <= '0;
            r_rst_a   <= 1'b0;
            r_freq_b  <= '0;
            r_multi_b <= '0;
            r_rst_b   <= 1'b0;
            r_inc_c   <= '0;
            r_rst_c   <= 1'b0;
        end else if (slot_en) begin
            r_freq_a  <= w_freq_a;
            r_dt_a    <= dt_val;
            r_multi_a <= multi;
            r_rst_a   <= pg_reset;
            r_freq_b  <= w_freq_b;
            r_multi_b <= r_multi_a;
            r_rst_b   <= r_rst_a;
            r_inc_c   <= PHASE_W'(w_inc);
            r_rst_c   <= r_rst_b;
        end
    end

    // The tail is the same slot's phase from one full ring rotation ago.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_ring[i] <= '0;
            end
            phase_out <= '0;
        end else if (slot_en) begin
            r_ring[0] <= w_new;
            for (int i = 1; i < SLOTS; i++) begin
                r_ring[i] <= r_ring[i-1];
            end
            phase_out <= w_new[PHASE_W-1 -: 10];
        end
    end

endmodule
